vigenere_seq_ctrl: RTL and testbench
====================================

# vigenere_seq_ctrl

Sequencer that turns the combinational mod-26 letter adder `ha1_task4` (ports P, K, C; C = (P+K) mod 26) into a streaming Vigenère cipher engine. It holds a loadable key of up to KEY_MAX_LEN letters and steps through it cyclically, one key letter per accepted plaintext letter. It supports encrypt and decrypt modes and presents valid/ready handshakes on input and output. It sits between a letter source (UART/keypad decoder) and a letter sink, with exactly one `ha1_task4` instance as its datapath.

## Interface
- KEY_MAX_LEN, 8, maximum key letters stored; legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- key_clear  in  1  in LOAD: empty the key (key_len := 0)
- key_wr  in  1  in LOAD: append key_in to the key
- key_in  in  5  key letter 0..25
- start  in  1  in LOAD: enter RUN if key_len != 0
- decrypt  in  1  sampled on accepted start; 1 = decrypt, 0 = encrypt
- stop  in  1  in RUN: end the message and return to LOAD
- in_valid  in  1  plaintext/ciphertext letter valid
- in_ready  out  1  block accepts in_p this cycle
- in_p  in  5  input letter
- out_valid  out  1  out_c valid
- out_ready  in  1  sink accepts out_c
- out_c  out  5  output letter
- key_len  out  4  number of stored key letters
- busy  out  1  state != LOAD
- err  out  1  one-cycle pulse: invalid letter or rejected key write

## Operation
- States: LOAD, RUN, DRAIN. Reset → LOAD.
- LOAD:
  - key_clear has priority over key_wr.
  - key_wr with key_in ≤ 25 and key_len < KEY_MAX_LEN writes key[key_len] and increments key_len.
  - Any other key_wr is ignored and pulses err the next cycle.
  - start with key_len != 0 (value before any same-cycle write) → RUN. It latches the decrypt input into the mode register and sets key_idx := 0.
  - start with key_len == 0 is ignored. A same-cycle write still takes effect.
- RUN:
  - in_ready = !out_valid || out_ready.
  - An accepted letter with in_p ≤ 25 drives P = in_p and K = key[key_idx] (encrypt), or K = (key[key_idx] == 0) ? 0 : 26 − key[key_idx] (decrypt). C is registered into out_c.
  - After each valid letter, key_idx := (key_idx == key_len − 1) ? 0 : key_idx + 1.
  - An accepted letter with in_p > 25 is passed through unchanged to out_c. key_idx does not advance, and err pulses the next cycle.
- stop in RUN:
  - Any handshake in the same cycle completes normally.
  - Next state is LOAD if no output will be pending, otherwise DRAIN.
- DRAIN:
  - in_ready = 0.
  - The state moves to LOAD in the cycle after out_valid && out_ready.
- In LOAD and DRAIN, key_wr, key_clear and start are ignored, except as LOAD rules state. stop is ignored outside RUN.
- On entering LOAD, key_idx := 0. Key contents and key_len are retained.

## Timing
- Reset values: out_valid 0, out_c 0, err 0, busy 0, key_len 0, in_ready 0, key_idx 0, mode 0. Key storage contents are don't-care.
- Reset mid-message drops any pending output in the same edge.
- Latency is 1 cycle: a letter accepted at edge n gives out_valid = 1 with out_c from edge n.
- Throughput is one letter per cycle when out_ready is held at 1.
- out_valid clears on out_valid && out_ready unless a new letter is accepted in the same cycle.
- While out_valid && !out_ready, out_c must hold stable.
- in_ready is combinational from state, out_valid and out_ready only. It must not depend on in_valid.
- busy reflects state registered at the current edge. RUN is entered the cycle after an accepted start.
- key_len updates the cycle after key_wr or key_clear.

## Test plan
- Load key 10,4,24; start encrypt; send 7,4,11,11,14 with out_ready = 1 → out_c 17,8,9,21,18 on consecutive cycles. Key wraps after the third letter.
- Reload the same key; start decrypt; send 17,8,9,21,18 → 7,4,11,11,14. Separately, key {0} in decrypt → identity. Key {25} encrypt with in_p 25 → 24.
- Backpressure: hold out_ready = 0 for 3 cycles with one letter pending → out_c stable, in_ready = 0. Release → the next letter is accepted the same cycle and ordering is preserved.
- Key {1,2}: send 26, then 0, 0 → out_c 26 with an err pulse, then 1, 2 (key_idx not advanced by the invalid letter).
- Write 9 letters with KEY_MAX_LEN = 8 → key_len = 8 and err on the 9th write. start with key_len 0 → busy stays 0.
- stop asserted while out_valid && !out_ready → DRAIN, in_ready = 0. LOAD follows the cycle after the output handshake. Assert rst mid-RUN → all outputs reach reset values at the next edge.

Source files
------------

// File: rtl/vigenere_seq_ctrl_if.sv
// Letter stream bundle: source-to-block input handshake and block-to-sink output handshake.
// The block takes the slave modport; the letter source/sink side takes master.
interface vigenere_seq_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_p;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_c;

  modport master (
    output in_valid, in_p, out_ready,
    input  in_ready, out_valid, out_c
  );

  modport slave (
    input  in_valid, in_p, out_ready,
    output in_ready, out_valid, out_c
  );
endinterface

// File: rtl/vigenere_seq_ctrl.sv
// Streaming Vigenere cipher sequencer around a single combinational mod-26 letter adder.
// Holds a cyclic key, handles encrypt/decrypt, and buffers one output letter.
module ha1_task4 (
  input  logic [4:0] P,
  input  logic [4:0] K,
  output logic [4:0] C
);
  logic [5:0] sum;

  always_comb begin
    sum = {1'b0, P} + {1'b0, K};
    C   = (sum >= 6'd26) ? 5'(sum - 6'd26) : sum[4:0];
  end
endmodule

module vigenere_seq_ctrl #(
  parameter int KEY_MAX_LEN = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       key_clear,
  input  logic                       key_wr,
  input  logic [4:0]                 key_in,
  input  logic                       start,
  input  logic                       decrypt,
  input  logic                       stop,
  vigenere_seq_ctrl_if.slave         strm,
  output logic [3:0]                 key_len,
  output logic                       busy,
  output logic                       err
);
  localparam logic [3:0] KEY_MAX = 4'(KEY_MAX_LEN);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] key_q [16];
  logic [4:0] key_d [16];
  logic [3:0] key_len_q, key_len_d;
  logic [3:0] key_idx_q, key_idx_d;
  logic       mode_q, mode_d;
  logic       out_valid_q, out_valid_d;
  logic [4:0] out_c_q, out_c_d;
  logic       err_q, err_d;

  logic       in_ready;
  logic       accept;
  logic       letter_ok;
  logic [4:0] k_raw;
  logic [4:0] k_sel;
  logic [4:0] c_sum;

  // Key selection and the single mod-26 adder
  always_comb begin
    k_raw     = key_q[key_idx_q];
    // Decrypt adds the additive inverse; a zero key letter is its own inverse.
    k_sel     = mode_q ? ((k_raw == 5'd0) ? 5'd0 : 5'd26 - k_raw) : k_raw;
    letter_ok = (strm.in_p <= 5'd25);
    in_ready  = (state_q == ST_RUN) && (!out_valid_q || strm.out_ready);
    accept    = in_ready && strm.in_valid;
  end

  ha1_task4 u_add (
    .P (strm.in_p),
    .K (k_sel),
    .C (c_sum)
  );

  // Next-state, key storage, output buffer
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_len_d   = key_len_q;
    key_idx_d   = key_idx_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    err_d       = 1'b0;

    if (out_valid_q && strm.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      out_valid_d = 1'b1;
      out_c_d     = letter_ok ? c_sum : strm.in_p;
    end

    unique case (state_q)
      ST_LOAD: begin
        if (key_clear) begin
          key_len_d = 4'd0;
        end else if (key_wr) begin
          if (key_in <= 5'd25 && key_len_q < KEY_MAX) begin
            key_d[key_len_q] = key_in;
            key_len_d        = key_len_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        // The go/no-go decision uses the key length before any same-cycle write.
        if (start && key_len_q != 4'd0) begin
          state_d   = ST_RUN;
          mode_d    = decrypt;
          key_idx_d = 4'd0;
        end
      end

      ST_RUN: begin
        if (accept) begin
          if (letter_ok) begin
            key_idx_d = (key_idx_q == key_len_q - 4'd1) ? 4'd0 : key_idx_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (stop) begin
          if (out_valid_d) begin
            state_d = ST_DRAIN;
          end else begin
            state_d   = ST_LOAD;
            key_idx_d = 4'd0;
          end
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && strm.out_ready) begin
          state_d   = ST_LOAD;
          key_idx_d = 4'd0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      key_len_q   <= 4'd0;
      key_idx_q   <= 4'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_c_q     <= 5'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_len_q   <= key_len_d;
      key_idx_q   <= key_idx_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      err_q       <= err_d;
    end
  end

  // Key letters carry no reset; key_len gates their use.
  always_ff @(posedge clk) begin
    key_q <= key_d;
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid_q;
  assign strm.out_c     = out_c_q;
  assign key_len        = key_len_q;
  assign busy           = (state_q != ST_LOAD);
  assign err            = err_q;
endmodule

// File: tb/tb_vigenere_seq_ctrl.sv
// Directed bench for vigenere_seq_ctrl: encrypt/decrypt streams, key limits,
// invalid letters, backpressure, stop/drain and mid-message reset.
module tb_vigenere_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       key_clear, key_wr, start, decrypt, stop;
  logic [4:0] key_in;
  logic [3:0] key_len;
  logic       busy, err;
  int         total = 0;
  int         bad   = 0;

  vigenere_seq_ctrl_if sif ();

  vigenere_seq_ctrl #(.KEY_MAX_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_clear (key_clear),
    .key_wr    (key_wr),
    .key_in    (key_in),
    .start     (start),
    .decrypt   (decrypt),
    .stop      (stop),
    .strm      (sif.slave),
    .key_len   (key_len),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [4:0] c);
    check({tag, ".vld"}, 32'(sif.out_valid), 32'(vld));
    if (vld) check({tag, ".c"}, 32'(sif.out_c), 32'(c));
  endtask

  task automatic wr_key(input logic [4:0] k);
    key_wr = 1'b1;
    key_in = k;
    tick();
    key_wr = 1'b0;
  endtask

  task automatic clr_key();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  task automatic go(input logic dec);
    start   = 1'b1;
    decrypt = dec;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
  endtask

  task automatic send(input logic [4:0] p);
    sif.in_valid = 1'b1;
    sif.in_p     = p;
    tick();
    sif.in_valid = 1'b0;
  endtask

  logic [4:0] plain  [5] = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
  logic [4:0] cipher [5] = '{5'd17, 5'd8, 5'd9, 5'd21, 5'd18};

  initial begin
    rst = 1'b1; key_clear = 0; key_wr = 0; key_in = 0; start = 0; decrypt = 0; stop = 0;
    sif.in_valid = 0; sif.in_p = 0; sif.out_ready = 0;
    tick(); tick();
    rst = 1'b0;
    check("rst.out_valid", 32'(sif.out_valid), 32'd0);
    check("rst.out_c", 32'(sif.out_c), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.key_len", 32'(key_len), 32'd0);
    check("rst.in_ready", 32'(sif.in_ready), 32'd0);

    // start with an empty key stays in LOAD
    go(1'b0);
    check("empty_start.busy", 32'(busy), 32'd0);

    // encrypt with key 10,4,24
    wr_key(5'd10); wr_key(5'd4); wr_key(5'd24);
    check("load3.key_len", 32'(key_len), 32'd3);
    sif.out_ready = 1'b1;
    go(1'b0);
    check("enc.busy", 32'(busy), 32'd1);
    check("enc.in_ready", 32'(sif.in_ready), 32'd1);
    sif.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sif.in_p = plain[i];
      tick();
      chk_out("enc", 1'b1, cipher[i]);
    end
    sif.in_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("enc_stop.busy", 32'(busy), 32'd0);
    check("enc_stop.out_valid", 32'(sif.out_valid), 32'd0);

    // decrypt with the same key after a clear and reload
    clr_key();
    check("clr.key_len", 32'(key_len), 32'd0);
    wr_key(5'd10); wr_key(5'd4); wr_key(5'd24);
    go(1'b1);
    sif.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sif.in_p = cipher[i];
      tick();
      chk_out("dec", 1'b1, plain[i]);
    end
    sif.in_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("dec_stop.busy", 32'(busy), 32'd0);

    // key {0} decrypt is identity
    clr_key(); wr_key(5'd0); go(1'b1);
    send(5'd13); chk_out("k0dec.a", 1'b1, 5'd13);
    send(5'd25); chk_out("k0dec.b", 1'b1, 5'd25);
    stop = 1'b1; tick(); stop = 1'b0;

    // key {25} encrypt of 25 wraps to 24
    clr_key(); wr_key(5'd25); go(1'b0);
    send(5'd25); chk_out("k25enc", 1'b1, 5'd24);
    stop = 1'b1; tick(); stop = 1'b0;

    // invalid letter passes through and does not advance the key
    clr_key(); wr_key(5'd1); wr_key(5'd2); go(1'b0);
    send(5'd26);
    chk_out("bad_letter", 1'b1, 5'd26);
    check("bad_letter.err", 32'(err), 32'd1);
    send(5'd0);
    chk_out("after_bad.a", 1'b1, 5'd1);
    check("after_bad.err", 32'(err), 32'd0);
    send(5'd0);
    chk_out("after_bad.b", 1'b1, 5'd2);
    tick();
    check("idle.out_valid", 32'(sif.out_valid), 32'd0);

    // backpressure: one pending letter held for 3 cycles
    send(5'd5);
    chk_out("bp.first", 1'b1, 5'd6);
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b1;
    sif.in_p      = 5'd7;
    #1;
    check("bp.in_ready0", 32'(sif.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("bp.hold", 1'b1, 5'd6);
      check("bp.hold.in_ready", 32'(sif.in_ready), 32'd0);
    end
    sif.out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", 32'(sif.in_ready), 32'd1);
    tick();
    chk_out("bp.next", 1'b1, 5'd9);
    sif.in_valid = 1'b0;
    tick();
    check("bp.done.out_valid", 32'(sif.out_valid), 32'd0);

    // stop with an output stuck behind out_ready=0 goes through DRAIN
    send(5'd3);
    chk_out("drain.pend", 1'b1, 5'd4);
    sif.out_ready = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    check("drain.busy", 32'(busy), 32'd1);
    check("drain.in_ready", 32'(sif.in_ready), 32'd0);
    chk_out("drain.hold", 1'b1, 5'd4);
    tick();
    check("drain.busy2", 32'(busy), 32'd1);
    sif.out_ready = 1'b1;
    #1;
    check("drain.in_ready_rdy", 32'(sif.in_ready), 32'd0);
    tick();
    check("drain.exit.busy", 32'(busy), 32'd0);
    check("drain.exit.out_valid", 32'(sif.out_valid), 32'd0);

    // key capacity and invalid key letters
    clr_key();
    wr_key(5'd30);
    check("badkey.err", 32'(err), 32'd1);
    check("badkey.key_len", 32'(key_len), 32'd0);
    for (int i = 0; i < 9; i++) begin
      wr_key(5'(i));
      check("fill.err", 32'(err), (i == 8) ? 32'd1 : 32'd0);
      check("fill.key_len", 32'(key_len), (i == 8) ? 32'd8 : 32'(i + 1));
    end
    tick();
    check("fill.err_clear", 32'(err), 32'd0);

    // reset in the middle of a message
    go(1'b0);
    sif.out_ready = 1'b0;
    send(5'd2);
    chk_out("mid.pend", 1'b1, 5'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst.out_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst.out_c", 32'(sif.out_c), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    check("mid_rst.key_len", 32'(key_len), 32'd0);
    check("mid_rst.err", 32'(err), 32'd0);
    check("mid_rst.in_ready", 32'(sif.in_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
